// File: rtl/fpu_issue_ctrl_if.sv
// Decode-to-issue handshake plus EX/ME buffer control and operand-forwarding selects.
interface fpu_issue_ctrl_if #(
  parameter int ASIZE = 5,
  parameter int LATW  = 3
);
  logic             id_valid;
  logic [ASIZE-1:0] id_rs1;
  logic [ASIZE-1:0] id_rs2;
  logic [ASIZE-1:0] id_rd;
  logic             id_wr;
  logic [LATW-1:0]  id_lat;
  logic             flush;
  logic             id_ready;
  logic             ex_start;
  logic             exme_en;
  logic [ASIZE-1:0] exme_rd;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic             ex_busy;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rd, id_wr, id_lat, flush,
    input  id_ready, ex_start, exme_en, exme_rd, fwd_a, fwd_b, ex_busy
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rd, id_wr, id_lat, flush,
    output id_ready, ex_start, exme_en, exme_rd, fwd_a, fwd_b, ex_busy
  );
endinterface

// File: rtl/fpu_issue_ctrl.sv
// Single-slot FPU issue controller: multi-cycle EX occupancy, RAW stall on the op in EX,
// and ME/WB destination tracking for operand forwarding.
module fpu_issue_ctrl #(
  parameter int ASIZE = 5,
  parameter int LATW  = 3
) (
  input logic           clk,
  input logic           rst_n,
  fpu_issue_ctrl_if.slave bus
);

  typedef enum logic {IDLE, EXEC} state_t;

  state_t           state, stateNext;
  logic [LATW-1:0]  cnt, cntNext;
  logic [ASIZE-1:0] exRd, exRdNext;
  logic             exWr, exWrNext;
  logic             meValid, wbValid;
  logic [ASIZE-1:0] meRd, wbRd;
  logic             hazard, accept, complete;
  logic [LATW-1:0]  latM1;

  function automatic logic [1:0] fwdSel(input logic [ASIZE-1:0] rs,
                                        input logic meV, input logic [ASIZE-1:0] meR,
                                        input logic wbV, input logic [ASIZE-1:0] wbR);
    if (meV && rs == meR)      return 2'b01;
    else if (wbV && rs == wbR) return 2'b10;
    else                       return 2'b00;
  endfunction

  // Outputs are gated by rst_n so they read 0 for the whole reset assertion.
  always_comb begin
    latM1     = (bus.id_lat == '0) ? '0 : bus.id_lat - LATW'(1);
    hazard    = bus.id_valid && (state == EXEC) && exWr &&
                (bus.id_rs1 == exRd || bus.id_rs2 == exRd);
    accept    = rst_n && bus.id_valid && !bus.flush && !hazard &&
                (state == IDLE || cnt == '0);
    complete  = rst_n && (state == EXEC) && (cnt == '0) && !bus.flush;
    stateNext = state;
    cntNext   = cnt;
    exRdNext  = exRd;
    exWrNext  = exWr;
    if (bus.flush) begin
      stateNext = IDLE;
      exWrNext  = 1'b0;
    end else if (accept) begin
      stateNext = EXEC;
      cntNext   = latM1;
      exRdNext  = bus.id_rd;
      exWrNext  = bus.id_wr;
    end else if (state == EXEC) begin
      if (cnt != '0) cntNext = cnt - LATW'(1);
      else           stateNext = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      exRd  <= '0;
      exWr  <= 1'b0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
      exRd  <= exRdNext;
      exWr  <= exWrNext;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meValid <= 1'b0;
      meRd    <= '0;
      wbValid <= 1'b0;
      wbRd    <= '0;
    end else begin
      meValid <= complete && exWr;
      if (complete) meRd <= exRd;
      wbValid <= meValid;
      wbRd    <= meRd;
    end
  end

  always_comb begin
    bus.id_ready = accept;
    bus.ex_start = accept;
    bus.exme_en  = complete;
    bus.exme_rd  = exRd;
    bus.ex_busy  = (state == EXEC);
    bus.fwd_a    = rst_n ? fwdSel(bus.id_rs1, meValid, meRd, wbValid, wbRd) : 2'b00;
    bus.fwd_b    = rst_n ? fwdSel(bus.id_rs2, meValid, meRd, wbValid, wbRd) : 2'b00;
  end

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Bench for fpu_issue_ctrl: directed vector table, reset sequence, and random traffic
// against a cycle-count based reference model.
module tb_fpu_issue_ctrl;
  localparam int ASIZE = 5;
  localparam int LATW  = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fpu_issue_ctrl_if #(.ASIZE(ASIZE), .LATW(LATW)) bus ();
  fpu_issue_ctrl #(.ASIZE(ASIZE), .LATW(LATW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit v; logic [4:0] rs1, rs2, rd; bit wr; logic [2:0] lat; bit fl;
    bit eReady, eEn; logic [4:0] eRd; bit eBusy; logic [1:0] eFa, eFb;
  } vec_t;
  vec_t tbl[$];

  // Reference model: op in EX completes at an absolute cycle number.
  int         mCyc = 0;
  bit         mExOcc = 0;
  int         mDone = 0;
  logic [4:0] mExRd = '0;
  bit         mExWr = 0;
  bit         mMeV = 0, mWbV = 0;
  logic [4:0] mMeRd = '0, mWbRd = '0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [1:0] mFwd(input logic [4:0] rs);
    if (mMeV && rs == mMeRd)      return 2'b01;
    else if (mWbV && rs == mWbRd) return 2'b10;
    else                          return 2'b00;
  endfunction

  function automatic vec_t mk(bit v, int rs1, int rs2, int rd, bit wr, int lat, bit fl,
                              bit r, bit en, int erd, bit busy, int fa, int fb);
    vec_t t;
    t.v = v; t.rs1 = 5'(rs1); t.rs2 = 5'(rs2); t.rd = 5'(rd); t.wr = wr;
    t.lat = 3'(lat); t.fl = fl; t.eReady = r; t.eEn = en; t.eRd = 5'(erd);
    t.eBusy = busy; t.eFa = 2'(fa); t.eFb = 2'(fb);
    return t;
  endfunction

  task automatic applyIn(input bit v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input bit wr, input logic [2:0] lat, input bit fl);
    bus.id_valid = v; bus.id_rs1 = rs1; bus.id_rs2 = rs2; bus.id_rd = rd;
    bus.id_wr = wr; bus.id_lat = lat; bus.flush = fl;
  endtask

  // Called mid-cycle: compares against the model, advances it, moves to next posedge+1.
  task automatic modelStep(input string tag);
    bit comp, haz, rdy, en;
    int lat;
    comp = mExOcc && (mCyc == mDone);
    haz  = bus.id_valid && mExOcc && mExWr && (bus.id_rs1 == mExRd || bus.id_rs2 == mExRd);
    rdy  = bus.id_valid && !bus.flush && !haz && (!mExOcc || comp);
    en   = comp && !bus.flush;
    check({tag, "_ready"}, 8'(bus.id_ready), 8'(rdy));
    check({tag, "_start"}, 8'(bus.ex_start), 8'(rdy));
    check({tag, "_en"},    8'(bus.exme_en),  8'(en));
    check({tag, "_rd"},    8'(bus.exme_rd),  8'(mExRd));
    check({tag, "_busy"},  8'(bus.ex_busy),  8'(mExOcc));
    if (bus.id_valid) begin
      check({tag, "_fwdA"}, 8'(bus.fwd_a), 8'(mFwd(bus.id_rs1)));
      check({tag, "_fwdB"}, 8'(bus.fwd_b), 8'(mFwd(bus.id_rs2)));
    end
    mWbV = mMeV; mWbRd = mMeRd;
    mMeV = en && mExWr;
    if (en) mMeRd = mExRd;
    lat = (bus.id_lat == 0) ? 1 : int'(bus.id_lat);
    if (bus.flush) begin
      mExOcc = 0; mExWr = 0;
    end else if (rdy) begin
      mExOcc = 1; mDone = mCyc + lat; mExRd = bus.id_rd; mExWr = bus.id_wr;
    end else if (comp) begin
      mExOcc = 0;
    end
    mCyc++;
    @(posedge clk); #1;
  endtask

  // Called at posedge+1: asynchronous reset for two edges, released at posedge+1.
  task automatic midReset(input string tag);
    rst_n = 1'b0;
    #1;
    check({tag, "_rst_ready"}, 8'(bus.id_ready), 8'd0);
    check({tag, "_rst_start"}, 8'(bus.ex_start), 8'd0);
    check({tag, "_rst_en"},    8'(bus.exme_en),  8'd0);
    check({tag, "_rst_rd"},    8'(bus.exme_rd),  8'd0);
    check({tag, "_rst_busy"},  8'(bus.ex_busy),  8'd0);
    check({tag, "_rst_fwdA"},  8'(bus.fwd_a),    8'd0);
    check({tag, "_rst_fwdB"},  8'(bus.fwd_b),    8'd0);
    mExOcc = 0; mExRd = '0; mExWr = 0; mMeV = 0; mMeRd = '0; mWbV = 0; mWbRd = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    //            v rs1 rs2 rd wr lat fl | rdy en erd busy fa fb
    tbl.push_back(mk(1, 1, 2, 3, 1, 1, 0,   1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 2, 4, 1, 1, 0,   1, 1, 3, 1, 0, 0));
    tbl.push_back(mk(1, 1, 2, 5, 1, 1, 0,   1, 1, 4, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,   0, 1, 5, 1, 0, 0));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 0, 0, 0));
    tbl.push_back(mk(1, 1, 2, 30, 1, 3, 0,  1, 0, 5, 0, 0, 0));
    tbl.push_back(mk(1, 30, 2, 6, 1, 1, 0,  0, 0, 30, 1, 0, 0));
    tbl.push_back(mk(1, 30, 2, 6, 1, 1, 0,  0, 0, 30, 1, 0, 0));
    tbl.push_back(mk(1, 30, 2, 6, 1, 1, 0,  0, 1, 30, 1, 0, 0));
    tbl.push_back(mk(1, 30, 2, 6, 1, 1, 0,  1, 0, 30, 0, 1, 0));
    tbl.push_back(mk(1, 1, 30, 8, 1, 1, 0,  1, 1, 6, 1, 0, 2));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,   0, 1, 8, 1, 0, 0));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 8, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 7, 1, 0, 0,   1, 0, 8, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,   0, 1, 7, 1, 0, 0));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 9, 1, 1, 0,   1, 0, 7, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 9, 1, 1, 0,   1, 1, 9, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,   0, 1, 9, 1, 0, 0));
    tbl.push_back(mk(1, 9, 9, 10, 0, 1, 0,  1, 0, 9, 0, 1, 1));
    tbl.push_back(mk(1, 10, 10, 11, 1, 2, 0, 1, 1, 10, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,   0, 0, 11, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,   0, 1, 11, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,   0, 0, 11, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 12, 1, 2, 0,  1, 0, 11, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,   0, 0, 12, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1,   0, 0, 12, 1, 0, 0));
    tbl.push_back(mk(1, 12, 12, 13, 1, 1, 0, 1, 0, 12, 0, 0, 0));
    tbl.push_back(mk(1, 12, 12, 14, 1, 1, 0, 1, 1, 13, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,   0, 1, 14, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,   0, 0, 14, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 15, 1, 1, 1,  0, 0, 14, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,   0, 0, 14, 0, 0, 0));

    applyIn(0, '0, '0, '0, 0, '0, 0);
    #1;
    check("init_ready", 8'(bus.id_ready), 8'd0);
    check("init_busy",  8'(bus.ex_busy),  8'd0);
    check("init_rd",    8'(bus.exme_rd),  8'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    foreach (tbl[i]) begin
      applyIn(tbl[i].v, tbl[i].rs1, tbl[i].rs2, tbl[i].rd, tbl[i].wr, tbl[i].lat, tbl[i].fl);
      #3;
      check($sformatf("row%0d_ready", i), 8'(bus.id_ready), 8'(tbl[i].eReady));
      check($sformatf("row%0d_en", i),    8'(bus.exme_en),  8'(tbl[i].eEn));
      check($sformatf("row%0d_rd", i),    8'(bus.exme_rd),  8'(tbl[i].eRd));
      check($sformatf("row%0d_busy", i),  8'(bus.ex_busy),  8'(tbl[i].eBusy));
      if (tbl[i].v) begin
        check($sformatf("row%0d_fwdA", i), 8'(bus.fwd_a), 8'(tbl[i].eFa));
        check($sformatf("row%0d_fwdB", i), 8'(bus.fwd_b), 8'(tbl[i].eFb));
      end
      modelStep($sformatf("row%0d_m", i));
    end

    // Reset pulled two cycles into an L=4 op; nothing of it may surface afterwards.
    applyIn(1, 5'd1, 5'd2, 5'd20, 1, 3'd4, 0); #3; modelStep("rs_acc");
    applyIn(0, '0, '0, '0, 0, '0, 0);          #3; modelStep("rs_w1");
    applyIn(1, 5'd20, 5'd20, 5'd22, 1, 3'd1, 0);
    midReset("rs");
    applyIn(0, '0, '0, '0, 0, '0, 0);
    for (int i = 0; i < 6; i++) begin
      #3;
      check($sformatf("rs_quiet%0d_en", i), 8'(bus.exme_en), 8'd0);
      modelStep($sformatf("rs_q%0d", i));
    end
    applyIn(1, 5'd1, 5'd2, 5'd21, 1, 3'd1, 0); #3;
    check("rs_new_ready", 8'(bus.id_ready), 8'd1);
    modelStep("rs_new");
    applyIn(0, '0, '0, '0, 0, '0, 0); #3;
    check("rs_new_en", 8'(bus.exme_en), 8'd1);
    check("rs_new_rd", 8'(bus.exme_rd), 8'd21);
    modelStep("rs_new_c");

    for (int i = 0; i < 400; i++) begin
      applyIn($urandom_range(0, 9) < 7, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
              5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
              $urandom_range(0, 9) == 0);
      if ($urandom_range(0, 149) == 0) begin
        midReset($sformatf("rnd%0d", i));
      end else begin
        #3;
        modelStep($sformatf("rnd%0d", i));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fpu_issue_ctrl.md
FPU_ISSUE_CTRL -- requirements
Module: fpu_issue_ctrl

Interface
REQ-001 Parameter ASIZE, default 5, register-address width; shares the global ASIZE value.
REQ-002 Parameter LATW, default 3, width of the per-instruction execute-latency field.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 id_valid  input  1  decode stage presents an instruction.
REQ-006 id_rs1, id_rs2  input  ASIZE  source register addresses.
REQ-007 id_rd  input  ASIZE  destination register address.
REQ-008 id_wr  input  1  instruction writes id_rd.
REQ-009 id_lat  input  LATW  execute cycles required; value 0 means 1.
REQ-010 flush  input  1  discard the instruction in EX and block issue this cycle.
REQ-011 id_ready  output  1  combinational; instruction accepted this cycle.
REQ-012 ex_start  output  1  combinational; equals id_ready; loads EX operand registers.
REQ-013 exme_en  output  1  combinational; load enable of the EX/ME buffer.
REQ-014 exme_rd  output  ASIZE  registered rd of the op in EX; feeds the buffer RDAddr input.
REQ-015 fwd_a, fwd_b  output  2  combinational operand select for rs1/rs2: 00 regfile, 01 ME result, 10 WB result.
REQ-016 ex_busy  output  1  registered; an op occupies EX.

Function
REQ-017 FSM states: IDLE (EX empty) and EXEC (EX occupied); down-counter cnt of width LATW.
REQ-018 Effective latency L = id_lat, or 1 when id_lat == 0.
REQ-019 Hazard: id_valid && ex_busy && ex_wr && (id_rs1 == exme_rd || id_rs2 == exme_rd); compare all addresses, with no special case for register 0.
REQ-020 Accept: id_valid && !flush && !hazard && (state == IDLE || cnt == 0).
REQ-021 On accept: load exme_rd <= id_rd, ex_wr <= id_wr, and cnt <= L-1; next state is EXEC.
REQ-022 In EXEC with cnt != 0 and !flush: cnt decrements; id_ready = 0.
REQ-023 In EXEC with cnt == 0 and !flush: assert exme_en for one cycle. Next state is EXEC when an accept occurs the same cycle; otherwise IDLE.
REQ-024 Latency: an op accepted in cycle N asserts exme_en in cycle N+L exactly. Back-to-back L=1 ops sustain one exme_en per cycle.
REQ-025 Flush: forces exme_en = 0 and id_ready = 0, and sets the next state to IDLE with ex_wr cleared.
REQ-026 Flush takes priority over completion at cnt == 0.
REQ-027 Flush does not alter ME/WB tracking.
REQ-028 ME tracking: me_valid <= exme_en && ex_wr; me_rd <= exme_rd when exme_en.
REQ-029 WB tracking: wb_valid <= me_valid; wb_rd <= me_rd.
REQ-030 fwd_a = 01 if me_valid && id_rs1 == me_rd; else 10 if wb_valid && id_rs1 == wb_rd; else 00. ME has priority over WB. fwd_b uses the same rule with id_rs2.
REQ-031 fwd_a and fwd_b are valid whenever id_valid, regardless of id_ready.
REQ-032 Stall persists while the matching op is in EX, including its completing cycle. The dependent instruction issues the cycle after exme_en, with forward select 01.
REQ-033 ex_busy = (state == EXEC).
REQ-034 cnt never wraps: it is loaded only on accept and decremented only when nonzero.

Reset
REQ-035 rst_n low immediately sets: state IDLE, cnt 0, exme_rd 0, ex_wr 0, me_valid 0, me_rd 0, wb_valid 0, wb_rd 0.
REQ-036 While rst_n is low: id_ready, ex_start, exme_en = 0; fwd_a, fwd_b = 00; ex_busy = 0.
REQ-037 Reset asserted mid-operation abandons the in-flight op; no exme_en is produced for it after release.
REQ-038 First accept is possible in the first rising edge after rst_n deasserts.

Verification
REQ-039 Independent L=1 ops, rd = 3, 4, 5, issued consecutively -> id_ready high 3 cycles; exme_en high cycles N+1..N+3; exme_rd 3, 4, 5.
REQ-040 L=3 op rd=30, then rs1=30 -> id_ready 0 for cycles N+1..N+3; accept at N+4 with fwd_a = 01. At N+5, a further rs2=30 yields fwd_b = 10.
REQ-041 id_lat = 0, rd=7 -> exme_en exactly one cycle after accept; exme_rd = 7.
REQ-042 L=2 op, flush asserted in its cnt == 0 cycle -> exme_en stays 0; ex_busy = 0 next cycle; me_valid stays 0.
REQ-043 L=4 op accepted, rst_n pulsed low two cycles later -> all outputs 0 at once; no exme_en after release; a new L=1 op issues normally.
REQ-044 rs1 matching both me_rd and wb_rd (both valid) -> fwd_a = 01.
